// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide datapath types.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/fetch_pkg.sv
// Fetch-stage FSM encoding and PC stepping constants.
package fetch_pkg;
  import cpu_types_pkg::*;

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    HALTED
  } fetch_state_t;

  localparam int unsigned PC_STEP    = 4;
  // Clears the byte-offset bits so every PC stays word aligned.
  localparam word_t       ALIGN_MASK = ~word_t'(PC_STEP - 1);

endpackage

// File: rtl/pc_reg.sv
// Program counter register: asynchronous active-low reset to PC_INIT, loads on enable.
module pc_reg
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  en_i,
  input  word_t pc_d_i,
  output word_t pc_o
);

  word_t pc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= PC_INIT;
    end else if (en_i) begin
      pc_q <= pc_d_i;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: requests words from the icache, holds each one for
// decode, then advances the PC sequentially, to a branch target, or stops on HALT.
module fetch_unit
  import cpu_types_pkg::*;
  import fetch_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  ihit,
  input  word_t iload,
  input  logic  stall,
  input  logic  halt,
  input  logic  pc_src,
  input  word_t branch_target,
  output logic  icuREN,
  output word_t iaddr,
  output word_t instr,
  output logic  instr_valid,
  output word_t pc,
  output word_t npc,
  output logic  halted
);

  fetch_state_t state_q, state_d;
  word_t        instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         halted_q, halted_d;
  logic         pc_en;
  word_t        pc_next;

  pc_reg #(
    .PC_INIT(PC_INIT)
  ) u_pc_reg (
    .clk_i (CLK),
    .rst_ni(nRST),
    .en_i  (pc_en),
    .pc_d_i(pc_next),
    .pc_o  (pc)
  );

  assign npc = pc + word_t'(PC_STEP);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= FETCH;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    pc_en    = 1'b0;
    pc_next  = npc;
    case (state_q)
      FETCH: begin
        if (ihit) begin
          instr_d = iload;
          valid_d = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // halt outranks pc_src; both are only honoured once the datapath is free.
        if (!stall) begin
          valid_d = 1'b0;
          if (halt) begin
            halted_d = 1'b1;
            state_d  = HALTED;
          end else begin
            pc_en   = 1'b1;
            pc_next = pc_src ? (branch_target & ALIGN_MASK) : npc;
            state_d = FETCH;
          end
        end
      end
      HALTED: begin
        halted_d = 1'b1;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign icuREN      = (state_q == FETCH);
  assign iaddr       = pc;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  nRST = 1'b0;
  logic  ihit = 1'b0;
  logic  stall = 1'b0;
  logic  halt = 1'b0;
  logic  pc_src = 1'b0;
  word_t iload = '0;
  word_t branch_target = '0;

  logic  icuREN, instr_valid, halted;
  word_t iaddr, instr, pc, npc;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 CLK = ~CLK;

  fetch_unit #(
    .PC_INIT(32'h0000_0000)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .ihit         (ihit),
    .iload        (iload),
    .stall        (stall),
    .halt         (halt),
    .pc_src       (pc_src),
    .branch_target(branch_target),
    .icuREN       (icuREN),
    .iaddr        (iaddr),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .npc          (npc),
    .halted       (halted)
  );

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Async reset pulse placed away from any rising edge; outputs must react at once.
  task automatic reset_pulse();
    #2 nRST = 1'b0;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_npc", npc, 32'h4);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_icuREN", {31'b0, icuREN}, 32'h1);
    #1 nRST = 1'b1;
    stall = 1'b0;
    tick();
  endtask

  task automatic fetch_one(input word_t addr, input word_t word);
    exp_t e;
    chk("fetch_icuREN", {31'b0, icuREN}, 32'h1);
    chk("fetch_iaddr", iaddr, addr);
    chk("fetch_npc", npc, addr + 32'd4);
    ihit  = 1'b1;
    iload = word;
    sb.push_back('{pc: addr, instr: word});
    tick();
    ihit  = 1'b0;
    iload = 32'hDEAD_BEEF;
    chk("latch_valid", {31'b0, instr_valid}, 32'h1);
    chk("exec_icuREN", {31'b0, icuREN}, 32'h0);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("sb_pc", pc, e.pc);
      chk("sb_instr", instr, e.instr);
    end else begin
      n_checks++;
      n_errors++;
      $error("FAIL sb_empty: observed empty queue expected entry");
    end
  endtask

  task automatic exec_step(input logic s_v, input logic h_v, input logic src_v, input word_t bt);
    stall         = s_v;
    halt          = h_v;
    pc_src        = src_v;
    branch_target = bt;
    tick();
    stall         = 1'b0;
    halt          = 1'b0;
    pc_src        = 1'b0;
    branch_target = 32'h1234_5677;
  endtask

  initial begin
    #12;
    chk("init_pc", pc, 32'h0);
    chk("init_instr", instr, 32'h0);
    chk("init_valid", {31'b0, instr_valid}, 32'h0);
    chk("init_halted", {31'b0, halted}, 32'h0);
    chk("init_icuREN", {31'b0, icuREN}, 32'h1);
    chk("init_npc", npc, 32'h4);
    @(negedge CLK);
    nRST = 1'b1;
    tick();

    // Sequential fetch, two cycles per instruction.
    for (int i = 0; i < 4; i++) begin
      fetch_one(word_t'(i * 4), 32'h2001_0005 + word_t'(i));
      exec_step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("seq_pc", pc, word_t'((i + 1) * 4));
      chk("seq_valid", {31'b0, instr_valid}, 32'h0);
    end

    // Icache miss: keep requesting the same address.
    repeat (5) begin
      tick();
      chk("miss_icuREN", {31'b0, icuREN}, 32'h1);
      chk("miss_iaddr", iaddr, 32'h10);
      chk("miss_valid", {31'b0, instr_valid}, 32'h0);
    end
    fetch_one(32'h10, 32'h8C22_0010);

    // Stall holds the instruction and PC.
    stall = 1'b1;
    repeat (3) begin
      tick();
      chk("stall_pc", pc, 32'h10);
      chk("stall_instr", instr, 32'h8C22_0010);
      chk("stall_valid", {31'b0, instr_valid}, 32'h1);
      chk("stall_icuREN", {31'b0, icuREN}, 32'h0);
    end
    stall = 1'b0;
    tick();
    chk("unstall_pc", pc, 32'h14);
    chk("unstall_icuREN", {31'b0, icuREN}, 32'h1);

    // Branch with misaligned target, then halt beating pc_src.
    fetch_one(32'h14, 32'h1000_000A);
    exec_step(1'b0, 1'b0, 1'b1, 32'h0000_0043);
    chk("br_iaddr", iaddr, 32'h40);
    fetch_one(32'h40, 32'h0800_0000);
    exec_step(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    chk("hs_halted", {31'b0, halted}, 32'h1);
    chk("hs_pc", pc, 32'h40);
    chk("hs_valid", {31'b0, instr_valid}, 32'h0);
    chk("hs_icuREN", {31'b0, icuREN}, 32'h0);
    reset_pulse();

    // Halt at 0x20 ignores icache activity until reset.
    fetch_one(32'h0, 32'h1111_0000);
    exec_step(1'b0, 1'b0, 1'b1, 32'h20);
    fetch_one(32'h20, 32'hFFFF_FFFF);
    exec_step(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (6) begin
      ihit   = ~ihit;
      iload  = $urandom;
      pc_src = 1'b1;
      tick();
      chk("hlt_icuREN", {31'b0, icuREN}, 32'h0);
      chk("hlt_halted", {31'b0, halted}, 32'h1);
      chk("hlt_pc", pc, 32'h20);
      chk("hlt_valid", {31'b0, instr_valid}, 32'h0);
    end
    ihit   = 1'b0;
    pc_src = 1'b0;
    reset_pulse();

    // Reset mid-stall at the top of the address space.
    fetch_one(32'h0, 32'h2222_0000);
    exec_step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    chk("top_pc", pc, 32'hFFFF_FFFC);
    chk("top_npc", npc, 32'h0);
    fetch_one(32'hFFFF_FFFC, 32'h3333_0000);
    stall = 1'b1;
    tick();
    tick();
    reset_pulse();

    // Sequential wrap from 0xFFFF_FFFC to 0.
    fetch_one(32'h0, 32'h4444_0000);
    exec_step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    fetch_one(32'hFFFF_FFFC, 32'h5555_0000);
    exec_step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_iaddr", iaddr, 32'h0);
    chk("wrap_icuREN", {31'b0, icuREN}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
